// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin using one full-subtractor cell, LSB first.
// Latency: start accepted at E0, bits at E1..E_WIDTH, done pulses in the cycle after E_WIDTH.
// Backpressure: none; start is only sampled in IDLE, so a host holding start high gets one op per WIDTH+2 cycles.
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   start           - request, sampled only in IDLE
//   a, b, bin       - minuend, subtrahend, borrow-in; captured on the accepted start edge
//   busy            - high while bits are being processed
//   done            - one-cycle pulse when diff/bout carry a fresh result
//   diff, bout      - registered difference and borrow-out of the last completed operation
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;

  // Single full-subtractor cell, fed from the bit selected by the counter.
  logic x_bit, y_bit, d_bit, bo_bit;
  always_comb begin
    x_bit  = a_q[cnt_q];
    y_bit  = b_q[cnt_q];
    d_bit  = x_bit ^ y_bit ^ brw_q;
    bo_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
  end

  always_comb begin
    logic [WIDTH-1:0] res;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    res     = sh_q;
    res[cnt_q] = d_bit;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        sh_d  = res;
        brw_d = bo_bit;
        cnt_d = cnt_q + CW'(1);
        // Publish only on the final bit so diff/bout keep the previous
        // result for the whole duration of a new operation.
        if (cnt_q == LAST) begin
          diff_d  = res;
          bout_d  = bo_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: an 8-bit instance and a 1-bit instance
// share the clock and reset; expected values are hand-computed constants.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [7:0] diff;
  logic       bout;

  logic       start1;
  logic [0:0] a1, b1;
  logic       bin1;
  logic       busy1, done1;
  logic [0:0] diff1;
  logic       bout1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 8-bit operation from IDLE. Operands are scrambled right after the
  // accept edge; pdiff/pbout is the previous result that must hold while busy.
  task automatic run_op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tbin, input logic [7:0] ediff, input logic ebout,
                         input logic [7:0] pdiff, input logic pbout);
    int  nbusy, lat;
    bit  got, hold_ok, excl_ok;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
    nbusy = 0; lat = 1; got = 0; hold_ok = 1; excl_ok = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy && done) excl_ok = 0;
      if (done) got = 1;
      else begin
        if (busy) nbusy++;
        if (diff !== pdiff || bout !== pbout) hold_ok = 0;
        tick();
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_hold_prev"}, 32'(hold_ok), 32'd1);
    check({tag, "_busy_done_excl"}, 32'(excl_ok), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(ediff));
    check({tag, "_bout"}, 32'(bout), 32'(ebout));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_diff_hold_idle"}, 32'(diff), 32'(ediff));
  endtask

  logic [7:0] bb_a   [3] = '{8'h10, 8'h80, 8'hC3};
  logic [7:0] bb_b   [3] = '{8'h20, 8'h7F, 8'h42};
  logic       bb_bin [3] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] bb_d   [3] = '{8'hF0, 8'h00, 8'h80};
  logic       bb_bo  [3] = '{1'b1, 1'b0, 1'b0};
  logic [1:0] w1_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [2:0] abc;
    logic [7:0] pd;
    logic       pb;
    bit         seen_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    run_op8("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8'h00, 1'b0);
    run_op8("op_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 8'h1E, 1'b0);
    run_op8("op_ff_ff_b1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Idle hold: result must persist with no start.
    repeat (5) tick();
    check("idle_hold_diff", 32'(diff), 32'hFF);

    // Back-to-back with start held high: one accept every 10 cycles.
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = bb_a[k]; b = bb_b[k]; bin = bb_bin[k];
      tick();
      check($sformatf("b2b%0d_busy_after_accept", k), 32'(busy), 32'd1);
      a = 8'hA5 ^ 8'(k); b = 8'h5A; bin = ~bin;
      repeat (7) tick();
      check($sformatf("b2b%0d_busy_last_bit", k), 32'(busy), 32'd1);
      tick();
      check($sformatf("b2b%0d_done", k), 32'(done), 32'd1);
      check($sformatf("b2b%0d_diff", k), 32'(diff), 32'(bb_d[k]));
      check($sformatf("b2b%0d_bout", k), 32'(bout), 32'(bb_bo[k]));
      tick();
      check($sformatf("b2b%0d_idle", k), 32'(busy | done), 32'd0);
    end
    start = 1'b0;
    tick();
    check("b2b_stop_busy", 32'(busy), 32'd0);

    // Asynchronous reset in RUN after 4 bits.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    tick();
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen_done = 1;
      tick();
    end
    check("arst_no_done", 32'(seen_done), 32'd0);
    check("arst_diff_after", 32'(diff), 32'd0);
    run_op8("post_rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 8'h00, 1'b0);

    // WIDTH=1 exhaustive.
    pd = 8'h00; pb = 1'b0;
    for (int v = 0; v < 8; v++) begin
      abc = 3'(v);
      a1 = abc[2]; b1 = abc[1]; bin1 = abc[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; bin1 = ~bin1;
      check($sformatf("w1_%0d_busy", v), 32'(busy1), 32'd1);
      check($sformatf("w1_%0d_done_early", v), 32'(done1), 32'd0);
      tick();
      check($sformatf("w1_%0d_done", v), 32'(done1), 32'd1);
      check($sformatf("w1_%0d_busy_off", v), 32'(busy1), 32'd0);
      check($sformatf("w1_%0d_res", v), {30'd0, diff1, bout1}, 32'(w1_exp[v]));
      tick();
      check($sformatf("w1_%0d_done_clr", v), 32'(done1), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial N-bit subtractor controller that computes diff = a - b - bin.
- Sequences one internal 1-bit full-subtractor cell LSB-first, one bit per clock.
- Keeps the running borrow in a flip-flop between bits.
- Start/busy/done handshake lets a host use a single full-subtractor cell for multi-bit subtraction.
- Sits between operand-producing logic and any consumer of the difference and borrow.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
bin  input  1  borrow-in; captured on the accepted start edge
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse: diff/bout valid
diff  output  WIDTH  registered difference of the last completed operation
bout  output  1  registered borrow-out of the last completed operation

Behaviour:
- Reset (async, active-high, any state):
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0.
  - Internal operand registers, shift register, bit counter and borrow flop all cleared.
  - An in-flight operation is abandoned: no done pulse, and diff/bout read 0 after reset.
- Full-subtractor cell, per bit i, with x = a_reg[i], y = b_reg[i], c = borrow flop:
  - d = x ^ y ^ c
  - bo = (~x & y) | (~(x ^ y) & c)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at an edge latches a, b into internal registers, bin into the borrow flop, clears the bit counter, and moves to RUN.
  - start = 0: stay in IDLE.
- RUN:
  - busy = 1.
  - Each edge: compute bit (counter), shift d into the result shift register at position counter, borrow flop <= bo, counter increments.
  - On the edge processing bit WIDTH-1: diff <= full result, bout <= bo, move to DONE.
  - start is ignored while in RUN.
- DONE:
  - busy = 0, done = 1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally; start is ignored in DONE.
- Latency:
  - start accepted at edge E0; bits processed at edges E1..E_WIDTH.
  - done high in the cycle following E_WIDTH.
  - busy high for exactly WIDTH cycles.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Output stability:
  - diff/bout change only at the final RUN edge, or on reset.
  - They hold the previous result throughout a new operation, and hold indefinitely in IDLE.
- Operand isolation: a, b and bin may change freely after the accepted start edge; the result depends only on the captured values.
- Arithmetic is modulo 2^WIDTH. bout = 1 iff a < b + bin as unsigned values.
- WIDTH = 1: RUN lasts a single cycle; behaviour equals one full-subtractor evaluation.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulsed 1 cycle -> busy high 8 cycles, done pulses on the 9th cycle after start, diff=0x1E, bout=0.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
- WIDTH=8, a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Back-to-back: start held high continuously with changing a/b -> operations accepted only in IDLE, one every 10 cycles. Each result matches the a/b/bin present at its accept edge; inputs changed mid-RUN have no effect.
- Reset asserted asynchronously in RUN after 4 bits of a=0x5A, b=0x3C -> busy/diff/bout go to 0 immediately with no done pulse. A new start after release runs normally to diff=0x1E.
- WIDTH=1 exhaustive over all 8 (a,b,bin) combinations -> (diff,bout) = 00,11,11,01,10,00,00,11 for abc = 000..111, done 2 cycles after each start.
